// File: rtl/mor1kx_bus_arb_pkg.sv
// Shared types for the ibus/dbus arbiter: FSM state encodings, owner ids and
// the downstream request bundle.
package mor1kx_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IBUS = 1'b0,
    OWNER_DBUS = 1'b1
  } owner_t;

  typedef struct packed {
    logic        req;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  bsel;
    logic        we;
  } bus_req_t;

  function automatic owner_t state_owner(arb_state_t s);
    return (s == DBUS) ? OWNER_DBUS : OWNER_IBUS;
  endfunction

endpackage

// File: rtl/mor1kx_bus_arb_watchdog.sv
// Access timeout counter: counts owned cycles and pulses expire in the
// TIMEOUT_CYCLES-th one. Only instantiated with MOR1KX_BUS_ARB_WATCHDOG_EN.
module mor1kx_bus_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic owned,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // An IDLE cycle always separates accesses, so clearing while idle
  // guarantees a fresh count on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (!owned) cnt <= '0;
    else             cnt <= cnt + CW'(1);
  end

  assign expire = owned && (cnt == LAST);

endmodule

// File: rtl/mor1kx_bus_arbiter.sv
// Round-robin arbiter sharing one single-access bus port between ibus and dbus.
// Define MOR1KX_BUS_ARB_WATCHDOG_EN to terminate accesses that never complete.
module mor1kx_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ibus_adr_i,
  input  logic [31:0] ibus_dat_i,
  input  logic        ibus_req_i,
  input  logic [3:0]  ibus_bsel_i,
  input  logic        ibus_we_i,
  output logic        ibus_ack_o,
  output logic        ibus_err_o,
  output logic [31:0] ibus_dat_o,
  input  logic [31:0] dbus_adr_i,
  input  logic [31:0] dbus_dat_i,
  input  logic        dbus_req_i,
  input  logic [3:0]  dbus_bsel_i,
  input  logic        dbus_we_i,
  output logic        dbus_ack_o,
  output logic        dbus_err_o,
  output logic [31:0] dbus_dat_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  output logic        bus_req_o,
  output logic [3:0]  bus_bsel_o,
  output logic        bus_we_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_dat_i
);

  import mor1kx_bus_arb_pkg::*;

  arb_state_t state, state_nxt;
  owner_t     last_owner;
  bus_req_t   ireq, dreq, mux;
  logic       owned, owner_req, expire, to_err;

  assign ireq = '{req: ibus_req_i, adr: ibus_adr_i, dat: ibus_dat_i,
                  bsel: ibus_bsel_i, we: ibus_we_i};
  assign dreq = '{req: dbus_req_i, adr: dbus_adr_i, dat: dbus_dat_i,
                  bsel: dbus_bsel_i, we: dbus_we_i};

  assign owned     = (state != IDLE);
  assign owner_req = (state == IBUS) ? ibus_req_i :
                     (state == DBUS) ? dbus_req_i : 1'b0;

`ifdef MOR1KX_BUS_ARB_WATCHDOG_EN
  mor1kx_bus_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .owned  (owned),
    .expire (expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  // A timeout only reports as an error when the bus did not ack that cycle.
  assign to_err = expire && !bus_ack_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWNER_IBUS;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE)
        last_owner <= state_owner(state_nxt);
    end
  end

  always_comb begin
    state_nxt  = state;
    mux        = '0;
    ibus_ack_o = 1'b0;
    ibus_err_o = 1'b0;
    dbus_ack_o = 1'b0;
    dbus_err_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (ibus_req_i && dbus_req_i)
          state_nxt = (last_owner == OWNER_IBUS) ? DBUS : IBUS;
        else if (ibus_req_i)
          state_nxt = IBUS;
        else if (dbus_req_i)
          state_nxt = DBUS;
      end
      IBUS: begin
        mux        = ireq;
        ibus_ack_o = bus_ack_i;
        ibus_err_o = bus_err_i || to_err;
      end
      DBUS: begin
        mux        = dreq;
        dbus_ack_o = bus_ack_i;
        dbus_err_o = bus_err_i || to_err;
      end
      default: state_nxt = IDLE;
    endcase
    // Every termination returns to IDLE, forcing bus_req_o low between accesses.
    if (owned && (bus_ack_i || bus_err_i || !owner_req || expire))
      state_nxt = IDLE;
  end

  assign bus_req_o  = mux.req;
  assign bus_adr_o  = mux.adr;
  assign bus_dat_o  = mux.dat;
  assign bus_bsel_o = mux.bsel;
  assign bus_we_o   = mux.we;

  assign ibus_dat_o = bus_dat_i;
  assign dbus_dat_o = bus_dat_i;

endmodule
